// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename tags, ROB commit and flush
module reg_file #(
    parameter int REG_COUNT    = 32,
    parameter int REG_ID_WIDTH = 5,
    parameter int XLEN         = 32,
    parameter int ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    reset_from_rob_bus,
    input  logic                    valid_from_issuer,
    input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
    input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
    input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
    output logic [XLEN-1:0]         vj_to_issuer,
    output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
    output logic [XLEN-1:0]         vk_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
    input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
    input  logic [XLEN-1:0]         value_from_rob
);

    // Entry 0 exists only for uniform indexing; it is never written so x0 stays zero.
    logic [XLEN-1:0]         value [REG_COUNT];
    logic [ROB_ID_WIDTH-1:0] tag   [REG_COUNT];

    logic commit_en;
    logic rename_en;

    assign commit_en = (dest_from_rob != '0) && (rd_from_rob != '0);
    assign rename_en = valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                value[r] <= '0;
                tag[r]   <= '0;
            end
        end else if (rdy) begin
            if (reset_from_rob_bus) begin
                for (int r = 0; r < REG_COUNT; r++) begin
                    tag[r] <= '0;
                end
            end else if (commit_en && tag[rd_from_rob] == dest_from_rob) begin
                tag[rd_from_rob] <= '0;
            end
            if (commit_en) begin
                value[rd_from_rob] <= value_from_rob;
            end
            // Placed last so a same-cycle rename overrides the commit's tag clear.
            if (rename_en) begin
                tag[rd_from_issuer] <= dest_from_issuer;
            end
        end
    end

    function automatic logic [ROB_ID_WIDTH+XLEN-1:0] read_src(
        input logic [REG_ID_WIDTH-1:0] rs
    );
        logic [ROB_ID_WIDTH-1:0] q;
        logic [XLEN-1:0]         v;
        q = '0;
        v = '0;
        if (rs != '0) begin
            if (tag[rs] != '0 && dest_from_rob == tag[rs] && rd_from_rob == rs) begin
                v = value_from_rob;
            end else begin
                q = tag[rs];
                v = value[rs];
            end
        end
        return {q, v};
    endfunction

    always_comb begin
        {qj_to_issuer, vj_to_issuer} = read_src(rs1_from_issuer);
        {qk_to_issuer, vk_to_issuer} = read_src(rs2_from_issuer);
    end

endmodule
